// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting controller.
//   state_t      : controller states (run, three edit fields, commit)
//   field_t      : display field codes driven on o_field
//   HOUR_MAX     : largest legal hour value
//   MIN_SEC_MAX  : largest legal minute / second value
//   field_of()   : field code shown while in a given state
//   is_set()     : true in the three edit states
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_t;

    localparam int HOUR_MAX    = 23;
    localparam int MIN_SEC_MAX = 59;

    function automatic field_t field_of(input state_t s);
        case (s)
            ST_SET_HOUR: return FIELD_HOUR;
            ST_SET_MIN:  return FIELD_MIN;
            ST_SET_SEC:  return FIELD_SEC;
            default:     return FIELD_NONE;
        endcase
    endfunction

    function automatic logic is_set(input state_t s);
        return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

endpackage

// File: rtl/wrap_adj.sv
// One editable time field with wrap-around increment / decrement.
//   clk, reset   : clock, synchronous active-low reset (value clears to 0)
//   i_capture    : load i_cap_val this cycle (takes priority over inc/dec)
//   i_cap_val    : value to capture
//   i_inc, i_dec : step up / down; both together means no change
//   o_val        : registered field value, always within 0..P_MAX after an adjust
module wrap_adj #(
    parameter int P_W   = 6,
    parameter int P_MAX = 59
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_capture,
    input  logic [P_W-1:0] i_cap_val,
    input  logic           i_inc,
    input  logic           i_dec,
    output logic [P_W-1:0] o_val
);

    localparam logic [P_W-1:0] MAX_V = P_W'(P_MAX);
    localparam logic [P_W-1:0] ONE_V = P_W'(1);

    logic [P_W-1:0] val_q;
    logic [P_W-1:0] val_d;

    // Out-of-range values (possible only via capture) fold back into range
    // on the first adjust: inc goes to 0, dec goes to the maximum.
    always_comb begin
        val_d = val_q;
        if (i_capture) begin
            val_d = i_cap_val;
        end else if (i_inc && !i_dec) begin
            val_d = (val_q >= MAX_V) ? '0 : val_q + ONE_V;
        end else if (i_dec && !i_inc) begin
            val_d = ((val_q == '0) || (val_q > MAX_V)) ? MAX_V : val_q - ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign o_val = val_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Run / time-setting sequencer for the sec-min-hour counter chain.
//   clk, reset        : clock, synchronous active-low reset
//   i_one_sec_tick    : one-second pulse from the tick generator
//   mode_btn          : enter setting / next field / commit
//   inc_btn, dec_btn  : adjust the selected field
//   cur_sec/min/hour  : live time from the counter chain
//   o_run_tick        : tick passed to the counter chain (RUN only)
//   o_load            : one-cycle load strobe with the edited time
//   o_sec/min/hour    : edit registers (load value and display value)
//   o_setting         : high in the edit states
//   o_field           : 0 none, 1 hour, 2 min, 3 sec
//   o_blink           : blink phase for the selected field
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_RUN      | counter chain runs, edit regs follow cur_*
// ST_SET_HOUR | chain frozen, editing hours
// ST_SET_MIN  | chain frozen, editing minutes
// ST_SET_SEC  | chain frozen, editing seconds
// ST_COMMIT   | single cycle: o_load pushes edited time to the chain
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5,
    parameter int P_TIMEOUT  = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_one_sec_tick,
    input  logic                  mode_btn,
    input  logic                  inc_btn,
    input  logic                  dec_btn,
    input  logic [P_SEC_BIT-1:0]  cur_sec,
    input  logic [P_MIN_BIT-1:0]  cur_min,
    input  logic [P_HOUR_BIT-1:0] cur_hour,
    output logic                  o_run_tick,
    output logic                  o_load,
    output logic [P_SEC_BIT-1:0]  o_sec,
    output logic [P_MIN_BIT-1:0]  o_min,
    output logic [P_HOUR_BIT-1:0] o_hour,
    output logic                  o_setting,
    output logic [1:0]            o_field,
    output logic                  o_blink
);

    localparam int              CNT_W   = $clog2(P_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(P_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    logic in_set;
    logic any_btn;
    logic timeout_hit;
    logic adj_ok;
    logic capture;

    assign in_set  = is_set(state_q);
    assign any_btn = mode_btn | inc_btn | dec_btn;
    // A button in the same cycle as the final tick keeps the edit alive.
    assign timeout_hit = in_set && i_one_sec_tick && !any_btn && (cnt_q == TO_LAST);
    // mode wins over a simultaneous inc/dec.
    assign adj_ok  = in_set && !mode_btn;
    // Edit regs mirror the chain while running, so display needs no mux.
    assign capture = (state_q == ST_RUN);

    // State register and timer / blink flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mode_btn) state_d = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                if (mode_btn)         state_d = ST_SET_MIN;
                else if (timeout_hit) state_d = ST_RUN;
            end
            ST_SET_MIN: begin
                if (mode_btn)         state_d = ST_SET_SEC;
                else if (timeout_hit) state_d = ST_RUN;
            end
            ST_SET_SEC: begin
                if (mode_btn)         state_d = ST_COMMIT;
                else if (timeout_hit) state_d = ST_RUN;
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Inactivity timer and blink phase
    always_comb begin
        cnt_d = '0;
        if (in_set) begin
            if (any_btn)              cnt_d = '0;
            else if (timeout_hit)     cnt_d = '0;
            else if (i_one_sec_tick)  cnt_d = cnt_q + CNT_ONE;
            else                      cnt_d = cnt_q;
        end

        blink_d = blink_q;
        if (!is_set(state_d))                  blink_d = 1'b0;
        else if (in_set && (inc_btn | dec_btn)) blink_d = 1'b1;
        else if (in_set && i_one_sec_tick)      blink_d = ~blink_q;
    end

    // Output logic
    always_comb begin
        o_run_tick = (state_q == ST_RUN) && i_one_sec_tick;
        o_load     = (state_q == ST_COMMIT);
        o_setting  = in_set;
        o_field    = field_of(state_q);
        o_blink    = blink_q;
    end

    wrap_adj #(.P_W(P_HOUR_BIT), .P_MAX(HOUR_MAX)) u_hour (
        .clk       (clk),
        .reset     (reset),
        .i_capture (capture),
        .i_cap_val (cur_hour),
        .i_inc     (adj_ok && (state_q == ST_SET_HOUR) && inc_btn),
        .i_dec     (adj_ok && (state_q == ST_SET_HOUR) && dec_btn),
        .o_val     (o_hour)
    );

    wrap_adj #(.P_W(P_MIN_BIT), .P_MAX(MIN_SEC_MAX)) u_min (
        .clk       (clk),
        .reset     (reset),
        .i_capture (capture),
        .i_cap_val (cur_min),
        .i_inc     (adj_ok && (state_q == ST_SET_MIN) && inc_btn),
        .i_dec     (adj_ok && (state_q == ST_SET_MIN) && dec_btn),
        .o_val     (o_min)
    );

    wrap_adj #(.P_W(P_SEC_BIT), .P_MAX(MIN_SEC_MAX)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .i_capture (capture),
        .i_cap_val (cur_sec),
        .i_inc     (adj_ok && (state_q == ST_SET_SEC) && inc_btn),
        .i_dec     (adj_ok && (state_q == ST_SET_SEC) && dec_btn),
        .o_val     (o_sec)
    );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a cycle-level reference model and
// hand-computed literal expectations at key points.
module tb_time_set_ctrl;

    localparam int P_TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, mode = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [5:0] cur_sec = '0, cur_min = '0;
    logic [4:0] cur_hour = '0;

    logic       o_run_tick, o_load, o_setting, o_blink;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [1:0] o_field;

    time_set_ctrl #(
        .P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5), .P_TIMEOUT(P_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_one_sec_tick (tick),
        .mode_btn       (mode),
        .inc_btn        (inc),
        .dec_btn        (dec),
        .cur_sec        (cur_sec),
        .cur_min        (cur_min),
        .cur_hour       (cur_hour),
        .o_run_tick     (o_run_tick),
        .o_load         (o_load),
        .o_sec          (o_sec),
        .o_min          (o_min),
        .o_hour         (o_hour),
        .o_setting      (o_setting),
        .o_field        (o_field),
        .o_blink        (o_blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int rt_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: m_fld 0 = running, 1..3 = editing hour/min/sec, 4 = commit
    int m_fld, m_h, m_m, m_s, m_cnt, m_delta;
    bit m_blink;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_fld = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_blink = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_fld == 0) begin
                m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
                if (mode) begin m_fld = 1; m_cnt = 0; end
            end else if (m_fld == 4) begin
                m_fld = 0;
            end else begin
                m_delta = 0;
                if (!mode && inc && !dec) m_delta = 1;
                if (!mode && dec && !inc) m_delta = -1;
                if (m_fld == 1) m_h = (m_h + m_delta + 24) % 24;
                if (m_fld == 2) m_m = (m_m + m_delta + 60) % 60;
                if (m_fld == 3) m_s = (m_s + m_delta + 60) % 60;
                if (inc || dec)  m_blink = 1;
                else if (tick)   m_blink = !m_blink;
                if (mode || inc || dec) m_cnt = 0;
                else if (tick)          m_cnt = m_cnt + 1;
                if (mode) m_fld = m_fld + 1;
                else if (m_cnt == P_TIMEOUT) begin m_fld = 0; m_cnt = 0; end
                if (m_fld == 0 || m_fld == 4) m_blink = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("run_tick", o_run_tick, (m_fld == 0) && tick);
            chk("load",     o_load,     m_fld == 4);
            chk("setting",  o_setting,  (m_fld >= 1) && (m_fld <= 3));
            chk("field",    o_field,    ((m_fld >= 1) && (m_fld <= 3)) ? m_fld : 0);
            chk("blink",    o_blink,    m_blink);
            chk("hour",     o_hour,     m_h);
            chk("min",      o_min,      m_m);
            chk("sec",      o_sec,      m_s);
            if (o_load)     load_cnt++;
            if (o_run_tick) rt_cnt++;
        end
    end

    task automatic cyc(input bit m, input bit i, input bit d, input bit t);
        mode = m; inc = i; dec = d; tick = t;
        @(posedge clk); #1;
        mode = 0; inc = 0; dec = 0; tick = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    int base_load, base_rt;

    initial begin
        set_cur(10, 20, 30);
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset state
        chk("rst_setting", o_setting, 0);
        chk("rst_field",   o_field,   0);
        chk("rst_load",    o_load,    0);
        chk("rst_blink",   o_blink,   0);
        chk("rst_hour",    o_hour,    0);

        // Running: three ticks pass straight through
        idle(1);
        base_rt = rt_cnt;
        cyc(0, 0, 0, 1); idle(1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        chk("run_3_ticks", rt_cnt - base_rt, 3);
        chk("track_hour",  o_hour, 10);

        // Full set 10:20:30 -> 12:19:30
        base_load = load_cnt;
        base_rt   = rt_cnt;
        cyc(1, 0, 0, 0);
        chk("set_hour_field", o_field, 1);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("hour_inc2", o_hour, 12);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("min_dec1", o_min, 19);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("commit_load", o_load, 1);
        chk("commit_hour", o_hour, 12);
        chk("commit_min",  o_min,  19);
        chk("commit_sec",  o_sec,  30);
        idle(1);
        chk("load_drop", o_load, 0);
        idle(1);
        chk("load_once", load_cnt - base_load, 1);
        chk("frozen_ticks", rt_cnt - base_rt, 0);

        // Wrap boundaries
        set_cur(23, 0, 59);
        idle(2);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        chk("hour_wrap_up", o_hour, 0);
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        chk("min_wrap_dn", o_min, 59);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        chk("sec_wrap_up", o_sec, 0);
        cyc(1, 0, 0, 0);
        chk("wrap_load", o_load, 1);
        chk("wrap_hms", {o_hour, o_min, o_sec}, {5'd0, 6'd59, 6'd0});
        idle(2);

        // Simultaneous buttons
        set_cur(5, 10, 15);
        idle(2);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        chk("incdec_nochg", o_hour, 5);
        cyc(1, 1, 0, 0);
        chk("mode_wins_field", o_field, 2);
        chk("mode_wins_hour",  o_hour,  5);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(2);

        // Timeout after 30 idle ticks, no load
        set_cur(1, 2, 3);
        idle(2);
        base_load = load_cnt;
        cyc(1, 0, 0, 0);
        repeat (P_TIMEOUT - 1) cyc(0, 0, 0, 1);
        chk("to_29_still_set", o_setting, 1);
        cyc(0, 0, 0, 1);
        chk("to_30_setting", o_setting, 0);
        chk("to_30_field",   o_field,   0);
        tick = 1'b1; #1;
        chk("to_resume_tick", o_run_tick, 1);
        @(posedge clk); #1; tick = 1'b0;
        chk("to_no_load", load_cnt - base_load, 0);

        // Button on the final tick keeps the edit and restarts the timer
        idle(1);
        cyc(1, 0, 0, 0);
        repeat (P_TIMEOUT - 1) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        chk("btn_beats_to_set",  o_setting, 1);
        chk("btn_beats_to_hour", o_hour,    2);
        repeat (P_TIMEOUT - 1) cyc(0, 0, 0, 1);
        chk("restart_29_set", o_setting, 1);
        cyc(0, 0, 0, 1);
        chk("restart_30_run", o_setting, 0);
        chk("to2_no_load", load_cnt - base_load, 0);

        // Reset in the middle of an edit
        set_cur(7, 8, 9);
        idle(2);
        base_load = load_cnt;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        chk("mid_min_inc", o_min, 9);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("mid_rst_field",   o_field,   0);
        chk("mid_rst_setting", o_setting, 0);
        chk("mid_rst_load",    o_load,    0);
        chk("mid_rst_hour",    o_hour,    0);
        idle(2);
        chk("mid_rst_noload", load_cnt - base_load, 0);
        chk("mid_rst_track",  o_min, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences the sec/minute/hour counter chain between normal running and user time-setting.
- Gates the one-second tick into the counter chain and walks an edit FSM through the hour, minute and second fields.
- Edits shadow copies of the fields, then issues a one-cycle load of the edited time back into the counter chain.
- Sits between the debounced button logic / one-second tick generator and the counter chain; also drives display-select and blink for the 7-segment driver.

Parameters:
- P_SEC_BIT, 6, width of the seconds field
- P_MIN_BIT, 6, width of the minutes field
- P_HOUR_BIT, 5, width of the hours field
- P_TIMEOUT, 30, number of one-sec ticks with no button activity before an edit is abandoned

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- i_one_sec_tick  input  1  one-cycle pulse from the tick generator
- mode_btn  input  1  one-cycle debounced pulse: enter setting / advance field / commit
- inc_btn  input  1  one-cycle debounced pulse: increment the selected field
- dec_btn  input  1  one-cycle debounced pulse: decrement the selected field
- cur_sec  input  P_SEC_BIT  live seconds from the counter chain
- cur_min  input  P_MIN_BIT  live minutes
- cur_hour  input  P_HOUR_BIT  live hours
- o_run_tick  output  1  gated tick to the counter chain
- o_load  output  1  one-cycle load strobe to the counter chain
- o_sec  output  P_SEC_BIT  edit seconds (load value and display)
- o_min  output  P_MIN_BIT  edit minutes
- o_hour  output  P_HOUR_BIT  edit hours
- o_setting  output  1  high in any SET state
- o_field  output  2  0 = none, 1 = hour, 2 = min, 3 = sec
- o_blink  output  1  blink phase for the selected field

Behaviour:
- Reset (reset==0 at a clk edge) gives:
  - state RUN
  - o_load = 0, o_setting = 0, o_field = 0, o_blink = 0
  - o_sec / o_min / o_hour = 0
  - timeout counter = 0
- States and transitions:
  - RUN → SET_HOUR → SET_MIN → SET_SEC → COMMIT → RUN
  - RUN: o_run_tick = i_one_sec_tick (combinational, zero latency).
    - On mode_btn: capture cur_hour / cur_min / cur_sec into the edit registers and go to SET_HOUR.
  - SET_*: o_run_tick = 0, so the counter chain is frozen.
    - mode_btn advances to the next field.
    - mode_btn in SET_SEC goes to COMMIT.
  - COMMIT: lasts exactly one cycle.
    - o_load = 1; o_sec / o_min / o_hour hold the edited values.
    - Next state RUN.
    - o_run_tick = 0 in COMMIT, even if a tick arrives that cycle.
- Field adjust, applied in the cycle after the button, on the selected field only:
  - hour wraps 23 → 0 on inc and 0 → 23 on dec.
  - min and sec wrap 59 → 0 and 0 → 59.
  - The result is never outside its range.
- Simultaneous events:
  - inc and dec in the same cycle: no change.
  - mode together with inc/dec: mode wins, the adjust is dropped.
  - Any button in RUN other than mode: ignored.
- Timeout:
  - The counter clears on entry to SET_HOUR and on any button pulse in SET_*.
  - It increments on each i_one_sec_tick in SET_*.
  - When it reaches P_TIMEOUT, go to RUN without a load; the counter chain resumes from its frozen values.
  - If a button and the final tick land in the same cycle, the button wins and the counter clears.
- Blink:
  - o_blink toggles on every i_one_sec_tick in SET_*.
  - It is forced to 1 for the cycle after any inc/dec, so the field stays visible while adjusting.
  - It is 0 in RUN.
- o_field: 1 / 2 / 3 in SET_HOUR / SET_MIN / SET_SEC; 0 otherwise.
- Edit registers: outside SET_*/COMMIT they track cur_* every cycle, so the display path needs no mux.
- Reset mid-edit: immediate return to RUN with no load; the counter chain keeps its pre-edit values.

Decomposition:
- Shared package (clock_pkg):
  - state encoding for RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT
  - field codes 0–3
  - limits HOUR_MAX = 23 and MIN_SEC_MAX = 59
- One sub-module, wrap_adj, instantiated three times:
  - a registered field with capture-load, inc/dec and a parameterized max, with wrap logic.

Test Plan:
- Reset then run: after reset is released, 3 ticks → o_run_tick pulses 3 times; o_setting = 0, o_load = 0.
- Full set: cur = 10:20:30; press mode, inc ×2, mode, dec ×1, mode, inc ×0, mode → COMMIT cycle has o_load = 1 with 12:19:30; o_load is 1 for exactly one cycle; no o_run_tick while in SET_*.
- Wrap: hour = 23 plus inc → 0; min = 0 plus dec → 59; sec = 59 plus inc → 0.
- Simultaneous: inc+dec same cycle → field unchanged; mode+inc in SET_HOUR → field advances to 2, hour unchanged.
- Timeout: enter SET_HOUR, send 30 ticks with no buttons → back to RUN, o_load never asserted; one more tick → o_run_tick = 1.
- Reset mid-edit: in SET_MIN after an edit, pull reset low for 1 cycle → state RUN, o_field = 0, no load.
